// File: rtl/clk_rate_ctrl_if.sv
// Rate-change request handshake between the system sequencer and clk_rate_ctrl.
interface clk_rate_ctrl_if;
  logic       req_valid;
  logic [1:0] req_rate;
  logic       req_ready;
  logic       rate_ack;

  modport master (output req_valid, output req_rate, input req_ready, input rate_ack);
  modport slave  (input req_valid, input req_rate, output req_ready, output rate_ack);
endinterface

// File: rtl/clk_rate_ctrl.sv
// Run-time divided-clock rate controller: one free-running master counter drives a
// selectable divided clock and enable strobe; rate changes land only at the cnt=0 boundary.
//
// state  | meaning
// RUN    | rate applied, request handshake open
// ALIGN  | request latched, waiting for the last cycle of the master period
module clk_rate_ctrl #(
  parameter int         DF_1     = 32,
  parameter int         DF_2     = 16,
  parameter int         DF_4     = 8,
  parameter logic [1:0] RST_RATE = 2'd0,
  parameter int         CNT_W    = 5
) (
  input  logic           clk_in,
  input  logic           reset,
  clk_rate_ctrl_if.slave req_if,
  output logic [1:0]     cur_rate_o,
  output logic           clk_out_o,
  output logic           clk_en_o,
  output logic           busy_o,
  output logic [7:0]     sw_count_o
);

  typedef enum logic {ST_RUN, ST_ALIGN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DF_1 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   MASK_1   = (CNT_W+1)'(DF_1 - 1);
  localparam logic [CNT_W:0]   MASK_2   = (CNT_W+1)'(DF_2 - 1);
  localparam logic [CNT_W:0]   MASK_4   = (CNT_W+1)'(DF_4 - 1);
  localparam logic [CNT_W:0]   HALF_1   = (CNT_W+1)'(DF_1 / 2);
  localparam logic [CNT_W:0]   HALF_2   = (CNT_W+1)'(DF_2 / 2);
  localparam logic [CNT_W:0]   HALF_4   = (CNT_W+1)'(DF_4 / 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_rate_q, cur_rate_d;
  logic [1:0]       pend_rate_q, pend_rate_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             rate_ack_q, rate_ack_d;
  logic [7:0]       sw_count_q, sw_count_d;
  logic [CNT_W:0]   mask, half, ph;

  // Divisors are powers of two, so the phase is just the masked counter.
  always_comb begin
    mask = MASK_1;
    half = HALF_1;
    case (cur_rate_q)
      2'd1:    begin mask = MASK_2; half = HALF_2; end
      2'd2:    begin mask = MASK_4; half = HALF_4; end
      default: begin mask = MASK_1; half = HALF_1; end
    endcase
    ph        = {1'b0, cnt_q} & mask;
    clk_out_d = (cur_rate_q != 2'd3) && (ph < half);
    clk_en_d  = (cur_rate_q != 2'd3) && (ph == mask);
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d     = state_q;
    cur_rate_d  = cur_rate_q;
    pend_rate_d = pend_rate_q;
    rate_ack_d  = 1'b0;
    sw_count_d  = sw_count_q;
    case (state_q)
      ST_RUN: begin
        if (req_if.req_valid) begin
          if (req_if.req_rate == cur_rate_q) begin
            rate_ack_d = 1'b1;
          end else begin
            pend_rate_d = req_if.req_rate;
            state_d     = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (cnt_q == CNT_LAST) begin
          cur_rate_d = pend_rate_q;
          rate_ack_d = 1'b1;
          state_d    = ST_RUN;
          if (sw_count_q != 8'hFF) sw_count_d = sw_count_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      cur_rate_q  <= RST_RATE;
      pend_rate_q <= RST_RATE;
      clk_out_q   <= 1'b0;
      clk_en_q    <= 1'b0;
      rate_ack_q  <= 1'b0;
      sw_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_rate_q  <= cur_rate_d;
      pend_rate_q <= pend_rate_d;
      clk_out_q   <= clk_out_d;
      clk_en_q    <= clk_en_d;
      rate_ack_q  <= rate_ack_d;
      sw_count_q  <= sw_count_d;
    end
  end

  assign req_if.req_ready = (state_q == ST_RUN);
  assign req_if.rate_ack  = rate_ack_q;
  assign busy_o           = (state_q == ST_ALIGN);
  assign cur_rate_o       = cur_rate_q;
  assign clk_out_o        = clk_out_q;
  assign clk_en_o         = clk_en_q;
  assign sw_count_o       = sw_count_q;

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Self-checking bench for clk_rate_ctrl: directed request table plus randomized traffic
// checked every cycle against a cycle-index-based reference model.
`timescale 1ns/1ps
module tb_clk_rate_ctrl;
  localparam int DF_1 = 32;
  localparam int DF_2 = 16;
  localparam int DF_4 = 8;
  localparam int RST  = 0;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [1:0] cur_rate;
  logic       clk_out, clk_en, busy;
  logic [7:0] sw_count;

  clk_rate_ctrl_if rif ();

  clk_rate_ctrl #(.DF_1(DF_1), .DF_2(DF_2), .DF_4(DF_4), .RST_RATE(2'(RST)), .CNT_W(5)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .req_if     (rif.slave),
    .cur_rate_o (cur_rate),
    .clk_out_o  (clk_out),
    .clk_en_o   (clk_en),
    .busy_o     (busy),
    .sw_count_o (sw_count)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: t counts cycles since reset release, so the master count is t mod DF_1.
  int t, m_cur, m_prev, m_pend, m_sw, m_ack_t, m_fast_t;
  bit m_pending;
  bit obs_ack;
  int obs_t;

  typedef struct { int rate; int acc_cnt; int exp_lat; int exp_sw; } dir_t;
  dir_t dir[6];

  function automatic int divisor(int rate);
    if (rate == 1) return DF_2;
    if (rate == 2) return DF_4;
    return DF_1;
  endfunction

  function automatic int exp_clk(int rate, int c);
    if (rate == 3) return 0;
    return ((c % divisor(rate)) < divisor(rate) / 2) ? 1 : 0;
  endfunction

  function automatic int exp_en(int rate, int c);
    if (rate == 3) return 0;
    return ((c % divisor(rate)) == divisor(rate) - 1) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got %0d expected %0d", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_cur = RST; m_prev = RST; m_pend = 0; m_sw = 0;
    m_pending = 0; m_ack_t = -1; m_fast_t = -1;
  endtask

  task automatic do_reset(input int n);
    rif.req_valid = 1'b0;
    reset = 1'b1;
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    model_reset();
  endtask

  // mode 0 idle, 1 request r, 2 noise only while model is busy, 3 random traffic
  task automatic tick(input int mode, input int r);
    int v, rr, e_ack;
    e_ack = 0;
    if (m_pending && t == m_ack_t) begin
      m_cur = m_pend;
      m_pending = 0;
      if (m_sw < 255) m_sw++;
      e_ack = 1;
    end
    if (t == m_fast_t) e_ack = 1;
    obs_ack = rif.rate_ack;
    obs_t   = t;
    chk("rate_ack",  32'(rif.rate_ack),  32'(e_ack));
    chk("cur_rate",  32'(cur_rate),      32'(m_cur));
    chk("clk_out",   32'(clk_out),       (t == 0) ? 0 : 32'(exp_clk(m_prev, (t - 1) % DF_1)));
    chk("clk_en",    32'(clk_en),        (t == 0) ? 0 : 32'(exp_en(m_prev, (t - 1) % DF_1)));
    chk("req_ready", 32'(rif.req_ready), 32'(!m_pending));
    chk("busy",      32'(busy),          32'(m_pending));
    chk("sw_count",  32'(sw_count),      32'(m_sw));
    v = 0; rr = r;
    if (mode == 1) v = 1;
    else if (mode == 2) begin v = m_pending ? int'($urandom % 2) : 0; rr = int'($urandom % 4); end
    else if (mode == 3) begin v = (($urandom % 10) != 0) ? 1 : 0; rr = int'($urandom % 4); end
    rif.req_valid = v[0];
    rif.req_rate  = rr[1:0];
    if (v != 0 && !m_pending) begin
      if (rr == m_cur) m_fast_t = t + 1;
      else begin
        m_pending = 1;
        m_pend    = rr;
        m_ack_t   = ((t + 2 + DF_1 - 1) / DF_1) * DF_1;
      end
    end
    m_prev = m_cur;
    @(posedge clk_in);
    @(negedge clk_in);
    t++;
  endtask

  initial begin
    int hi, en, acks, t_acc, lat;
    bit got;
    dir[0] = '{rate: 2, acc_cnt: 30, exp_lat: 2,  exp_sw: 1};
    dir[1] = '{rate: 1, acc_cnt: 31, exp_lat: 33, exp_sw: 2};
    dir[2] = '{rate: 1, acc_cnt: 5,  exp_lat: 1,  exp_sw: 2};
    dir[3] = '{rate: 3, acc_cnt: 0,  exp_lat: 32, exp_sw: 3};
    dir[4] = '{rate: 2, acc_cnt: 17, exp_lat: 15, exp_sw: 4};
    dir[5] = '{rate: 0, acc_cnt: 29, exp_lat: 3,  exp_sw: 5};

    rif.req_valid = 1'b0;
    rif.req_rate  = 2'd0;
    @(negedge clk_in);
    do_reset(3);

    hi = 0; en = 0;
    for (int i = 0; i < 64; i++) begin
      hi += int'(clk_out); en += int'(clk_en);
      tick(0, 0);
    end
    chk("intro_high_cycles", 32'(hi), 32);
    chk("intro_en_pulses",   32'(en), 1);

    for (int k = 0; k < 6; k++) begin
      while ((t % DF_1) != dir[k].acc_cnt) tick(0, 0);
      t_acc = t;
      tick(1, dir[k].rate);
      got = 0; lat = -1;
      for (int w = 0; w < 40 && !got; w++) begin
        tick(2, 0);
        if (obs_ack) begin got = 1; lat = obs_t - t_acc; end
      end
      if (!got) chk("ack_timeout", 0, 1);
      chk("ack_latency",   32'(lat),      32'(dir[k].exp_lat));
      chk("dir_sw_count",  32'(sw_count), 32'(dir[k].exp_sw));
      if (dir[k].rate == 3) begin
        hi = 0;
        for (int i = 0; i < 100; i++) begin
          hi += int'(clk_out) + int'(clk_en);
          tick(0, 0);
        end
        chk("off_activity", 32'(hi), 0);
      end
    end

    for (int i = 0; i < 12000; i++) tick(3, 0);
    for (int i = 0; i < 40; i++) tick(0, 0);

    do_reset(2);
    while ((t % DF_1) != 3) tick(0, 0);
    tick(1, 2);
    while ((t % DF_1) != 10) tick(0, 0);
    chk("align_busy", 32'(busy), 1);
    do_reset(1);
    chk("rst_cur_rate", 32'(cur_rate),      32'(RST));
    chk("rst_ready",    32'(rif.req_ready), 1);
    chk("rst_busy",     32'(busy),          0);
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0);
      acks += int'(obs_ack);
    end
    chk("dropped_req_acks", 32'(acks), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_rate_ctrl.md
Name: clk_rate_ctrl

Overview:
Run-time rate controller for the divided-clock scheme: one free-running master counter produces a single selectable divided clock (÷DF_1, ÷DF_2, ÷DF_4 or off) plus a matching one-cycle enable strobe.
- Rate changes are requested through a valid/ready handshake.
- Changes are applied only at the common period boundary, so the output never glitches or produces a runt pulse.
- Sits between the system sequencer and any logic clocked or enabled by the divided rates.

Parameters:
DF_1, 32, slowest divisor; master counter period; power of 2
DF_2, 16, middle divisor; must divide DF_1
DF_4, 8, fastest divisor; must divide DF_2
RST_RATE, 2'd0, rate code loaded at reset (0=÷DF_1, 1=÷DF_2, 2=÷DF_4, 3=off)
CNT_W, 5, master counter width, log2(DF_1)

Ports:
clk_in  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  rate-change request valid
req_rate  input  2  requested rate code
req_ready  output  1  controller can accept a request
rate_ack  output  1  one-cycle pulse: requested rate now in effect
cur_rate  output  2  rate code currently applied
clk_out  output  1  registered divided clock, 50% duty
clk_en  output  1  one-cycle strobe, once per selected period
busy  output  1  request pending alignment
sw_count  output  8  completed rate switches, saturating at 255

Behaviour:
- Reset values (sampled on clk_in while reset=1):
  - cnt=0, cur_rate=RST_RATE, clk_out=0, clk_en=0, rate_ack=0, busy=0, req_ready=1, sw_count=0, state=RUN.
  - Reset mid-operation discards any pending request and restores these values.
- Master counter cnt:
  - Increments every cycle, wraps DF_1-1 -> 0.
  - Never stops, including while rate is off or a request is pending.
- Selected divisor D = DF_1/DF_2/DF_4 for codes 0/1/2; ph = cnt mod D (low bits of cnt).
- Output registers, using cnt and cur_rate of cycle t:
  - clk_out(t+1) = (ph < D/2).
  - clk_en(t+1) = (ph == D-1).
  - Both outputs are forced to 0 when cur_rate=3.
- FSM states: RUN, ALIGN.
  - RUN: req_ready=1, busy=0. A request is accepted when req_valid && req_ready.
    - If req_rate == cur_rate: fast path. rate_ack=1 the next cycle, state stays RUN, sw_count unchanged.
    - Otherwise: latch req_rate into pend_rate; next cycle state=ALIGN, req_ready=0, busy=1.
  - ALIGN: on the edge where cnt==DF_1-1 is sampled, do all of the following together:
    - cur_rate <= pend_rate;
    - rate_ack <= 1 (high for exactly the cycle in which cnt=0);
    - req_ready <= 1, busy <= 0, state <= RUN;
    - sw_count <= sw_count+1, saturating at 255.
- Latency (acceptance cycle -> rate_ack high): 2 cycles if accepted at cnt=DF_1-2; up to DF_1+1 cycles if accepted at cnt=DF_1-1.
- Glitch-free guarantee: the last cycle of the old period has ph=D-1, so clk_out is low at every switch. The first high clk_out for the new rate appears in the cycle after cnt=0.
- req_valid while req_ready=0 is ignored. The requester holds the request until it sees req_ready. Payload changes made while req_ready=0 have no effect.
- Acceptance and switch in the same cycle are impossible, because req_ready=0 throughout ALIGN.
- Switching to off (code 3): clk_out and clk_en go to 0 from the cycle after the boundary.
- Switching from off: the new rate starts cleanly at cnt=0.

Test Plan:
- Reset, then 64 cycles with RST_RATE=0 -> clk_out repeats 16 high/16 low, clk_en pulses every 32 cycles, sw_count=0, req_ready=1.
- Request code 2 accepted at cnt=30 -> rate_ack high 2 cycles later with cnt=0, cur_rate=2, then clk_out 4 high/4 low, sw_count=1.
- Request code 1 accepted at cnt=31 -> busy=1 and req_ready=0 for 32 cycles, rate_ack 33 cycles after acceptance, no clk_out pulse shorter than 4 cycles at the switch.
- Request equal to cur_rate -> rate_ack on the next cycle, no ALIGN phase, sw_count unchanged. Toggle req_valid during ALIGN -> ignored.
- Request code 3 -> after ack, clk_out=0 and clk_en=0 for 100 cycles. Then request code 2 -> clean 4/4 waveform starting at cnt=0.
- Assert reset for 1 cycle mid-ALIGN (cnt=10) -> all outputs return to reset values, pending request dropped, no rate_ack, cur_rate=RST_RATE.
